// File: rtl/cc_regbank_pkg.sv
// Destination codes and helpers shared by the write side and the read-side selector
// of the datapath register bank.
package cc_regbank_pkg;

  localparam int REG_SEL_W = 4;
  localparam int REG_COUNT = 14;

  localparam logic [REG_SEL_W-1:0] REG_G0    = 4'd0;
  localparam logic [REG_SEL_W-1:0] REG_G1    = 4'd1;
  localparam logic [REG_SEL_W-1:0] REG_G2    = 4'd2;
  localparam logic [REG_SEL_W-1:0] REG_G3    = 4'd3;
  localparam logic [REG_SEL_W-1:0] REG_G4    = 4'd4;
  localparam logic [REG_SEL_W-1:0] REG_G5    = 4'd5;
  localparam logic [REG_SEL_W-1:0] REG_G6    = 4'd6;
  localparam logic [REG_SEL_W-1:0] REG_G7    = 4'd7;
  localparam logic [REG_SEL_W-1:0] REG_PC    = 4'd8;
  localparam logic [REG_SEL_W-1:0] REG_TEMP0 = 4'd9;
  localparam logic [REG_SEL_W-1:0] REG_TEMP1 = 4'd10;
  localparam logic [REG_SEL_W-1:0] REG_TEMP2 = 4'd11;
  localparam logic [REG_SEL_W-1:0] REG_TEMP3 = 4'd12;
  localparam logic [REG_SEL_W-1:0] REG_IR    = 4'd13;

  // Codes above IR (1110, 1111) address no register.
  function automatic logic is_valid_sel(input logic [REG_SEL_W-1:0] sel);
    return (sel <= REG_IR);
  endfunction

endpackage

// File: rtl/cc_regbank_wrstage.sv
// One-entry holding stage for register writes: valid/ready acceptance, hold freeze,
// and a commit strobe telling the bank when the held entry may be written.
module cc_regbank_wrstage
  import cc_regbank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SEL_W  = REG_SEL_W
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_hold,
  output logic              o_entry_valid,
  output logic [SEL_W-1:0]  o_entry_sel,
  output logic [DATA_W-1:0] o_entry_data,
  output logic              o_commit
);

  logic              r_pending;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_data;
  logic              w_accept;

  // An occupied stage can still take a new entry on the edge it drains.
  assign o_ready  = !srst && (!r_pending || !i_hold);
  assign o_commit = !srst && r_pending && !i_hold;
  assign w_accept = i_valid && o_ready;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_pending <= 1'b0;
      r_sel     <= '0;
      r_data    <= '0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
      r_sel     <= i_sel;
      r_data    <= i_data;
    end else if (o_commit) begin
      r_pending <= 1'b0;
    end
  end

  assign o_entry_valid = r_pending;
  assign o_entry_sel   = r_sel;
  assign o_entry_data  = r_data;

endmodule

// File: rtl/cc_regbank_writer.sv
// Write side of the datapath register bank: owns g0..g7, PC, Temp0..Temp3 and IR,
// commits held writes, auto-increments PC and flags invalid destination codes.
module cc_regbank_writer
  import cc_regbank_pkg::*;
#(
  parameter int                         DATAWIDTH_BUS           = 32,
  parameter int                         DATAWIDTH_REG_SELECTION = REG_SEL_W,
  parameter logic [DATAWIDTH_BUS-1:0]   PC_RESET_VALUE          = 32'h0000_0000,
  parameter int unsigned                PC_INCREMENT            = 4
) (
  input  logic                               CC_REGBANK_CLOCK_50,
  input  logic                               CC_REGBANK_RESET_InHigh,
  input  logic                               CC_REGBANK_WrValid_In,
  output logic                               CC_REGBANK_WrReady_Out,
  input  logic [DATAWIDTH_REG_SELECTION-1:0] CC_REGBANK_WrSel_In,
  input  logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_WrData_In,
  input  logic                               CC_REGBANK_Hold_In,
  input  logic                               CC_REGBANK_PCInc_In,
  output logic                               CC_REGBANK_Pending_Out,
  output logic                               CC_REGBANK_SelErr_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g0_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g1_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g2_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g3_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g4_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g5_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g6_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_g7_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_PC_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_Temp0_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_Temp1_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_Temp2_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_Temp3_Out,
  output logic [DATAWIDTH_BUS-1:0]           CC_REGBANK_IR_Out
);

  logic                               w_entry_valid;
  logic [DATAWIDTH_REG_SELECTION-1:0] w_entry_sel;
  logic [DATAWIDTH_BUS-1:0]           w_entry_data;
  logic                               w_commit;
  logic                               w_sel_ok;
  logic                               w_pc_write;
  logic                               w_pc_inc;

  logic [DATAWIDTH_BUS-1:0] r_regs [REG_COUNT];
  logic                     r_sel_err;

  cc_regbank_wrstage #(
    .DATA_W (DATAWIDTH_BUS),
    .SEL_W  (DATAWIDTH_REG_SELECTION)
  ) u_wrstage (
    .clk           (CC_REGBANK_CLOCK_50),
    .srst          (CC_REGBANK_RESET_InHigh),
    .i_valid       (CC_REGBANK_WrValid_In),
    .o_ready       (CC_REGBANK_WrReady_Out),
    .i_sel         (CC_REGBANK_WrSel_In),
    .i_data        (CC_REGBANK_WrData_In),
    .i_hold        (CC_REGBANK_Hold_In),
    .o_entry_valid (w_entry_valid),
    .o_entry_sel   (w_entry_sel),
    .o_entry_data  (w_entry_data),
    .o_commit      (w_commit)
  );

  assign w_sel_ok   = is_valid_sel(w_entry_sel);
  assign w_pc_write = w_commit && (w_entry_sel == REG_PC);
  // A committed PC write overrides a same-cycle increment.
  assign w_pc_inc   = CC_REGBANK_PCInc_In && !CC_REGBANK_Hold_In && !w_pc_write;

  always_ff @(posedge CC_REGBANK_CLOCK_50) begin
    if (CC_REGBANK_RESET_InHigh) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
      r_regs[REG_PC] <= PC_RESET_VALUE;
      r_sel_err      <= 1'b0;
    end else begin
      if (w_pc_inc) begin
        r_regs[REG_PC] <= r_regs[REG_PC] + DATAWIDTH_BUS'(PC_INCREMENT);
      end
      if (w_commit) begin
        if (!w_sel_ok) begin
          r_sel_err <= 1'b1;
        end else if (w_entry_sel != REG_G0) begin
          r_regs[w_entry_sel] <= w_entry_data;
        end
      end
    end
  end

  assign CC_REGBANK_Pending_Out = w_entry_valid;
  assign CC_REGBANK_SelErr_Out  = r_sel_err;

  // g0 reads as zero no matter what was committed to it.
  assign CC_REGBANK_g0_Out    = '0;
  assign CC_REGBANK_g1_Out    = r_regs[REG_G1];
  assign CC_REGBANK_g2_Out    = r_regs[REG_G2];
  assign CC_REGBANK_g3_Out    = r_regs[REG_G3];
  assign CC_REGBANK_g4_Out    = r_regs[REG_G4];
  assign CC_REGBANK_g5_Out    = r_regs[REG_G5];
  assign CC_REGBANK_g6_Out    = r_regs[REG_G6];
  assign CC_REGBANK_g7_Out    = r_regs[REG_G7];
  assign CC_REGBANK_PC_Out    = r_regs[REG_PC];
  assign CC_REGBANK_Temp0_Out = r_regs[REG_TEMP0];
  assign CC_REGBANK_Temp1_Out = r_regs[REG_TEMP1];
  assign CC_REGBANK_Temp2_Out = r_regs[REG_TEMP2];
  assign CC_REGBANK_Temp3_Out = r_regs[REG_TEMP3];
  assign CC_REGBANK_IR_Out    = r_regs[REG_IR];

endmodule

// File: tb/tb_cc_regbank_writer.sv
// Randomized self-checking bench for cc_regbank_writer against a behavioural
// register-bank model, with directed scenarios pinned by literal expectations.
module tb_cc_regbank_writer;

  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [3:0]  wr_sel = 4'd0;
  logic [31:0] wr_data = 32'd0;
  logic        hold = 1'b0;
  logic        pcinc = 1'b0;
  logic        wr_ready, pending, sel_err;
  logic [31:0] dut_regs [14];

  always #5 clk = ~clk;

  cc_regbank_writer dut (
    .CC_REGBANK_CLOCK_50     (clk),
    .CC_REGBANK_RESET_InHigh (rst),
    .CC_REGBANK_WrValid_In   (wr_valid),
    .CC_REGBANK_WrReady_Out  (wr_ready),
    .CC_REGBANK_WrSel_In     (wr_sel),
    .CC_REGBANK_WrData_In    (wr_data),
    .CC_REGBANK_Hold_In      (hold),
    .CC_REGBANK_PCInc_In     (pcinc),
    .CC_REGBANK_Pending_Out  (pending),
    .CC_REGBANK_SelErr_Out   (sel_err),
    .CC_REGBANK_g0_Out       (dut_regs[0]),
    .CC_REGBANK_g1_Out       (dut_regs[1]),
    .CC_REGBANK_g2_Out       (dut_regs[2]),
    .CC_REGBANK_g3_Out       (dut_regs[3]),
    .CC_REGBANK_g4_Out       (dut_regs[4]),
    .CC_REGBANK_g5_Out       (dut_regs[5]),
    .CC_REGBANK_g6_Out       (dut_regs[6]),
    .CC_REGBANK_g7_Out       (dut_regs[7]),
    .CC_REGBANK_PC_Out       (dut_regs[8]),
    .CC_REGBANK_Temp0_Out    (dut_regs[9]),
    .CC_REGBANK_Temp1_Out    (dut_regs[10]),
    .CC_REGBANK_Temp2_Out    (dut_regs[11]),
    .CC_REGBANK_Temp3_Out    (dut_regs[12]),
    .CC_REGBANK_IR_Out       (dut_regs[13])
  );

  int n_checks = 0;
  int n_err    = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a register file plus a queue holding at most one pending write.
  logic [31:0] m_regs [14];
  logic [3:0]  m_q_sel [$];
  logic [31:0] m_q_data [$];
  bit          m_sel_err;
  bit          m_last_accept;

  always @(posedge clk) begin
    bit can_take, drains, pc_written;
    m_last_accept = 0;
    if (rst) begin
      for (int i = 0; i < 14; i++) m_regs[i] = 32'd0;
      m_regs[8] = PC_RST;
      m_q_sel.delete();
      m_q_data.delete();
      m_sel_err = 0;
    end else begin
      can_take   = (m_q_sel.size() == 0) || !hold;
      drains     = (m_q_sel.size() != 0) && !hold;
      pc_written = 0;
      if (drains) begin
        logic [3:0]  s;
        logic [31:0] d;
        s = m_q_sel.pop_front();
        d = m_q_data.pop_front();
        if (s >= 4'd14) m_sel_err = 1;
        else if (s != 4'd0) m_regs[s] = d;
        if (s == 4'd8) pc_written = 1;
      end
      if (pcinc && !hold && !pc_written) m_regs[8] = m_regs[8] + 32'd4;
      if (wr_valid && can_take) begin
        m_q_sel.push_back(wr_sel);
        m_q_data.push_back(wr_data);
        m_last_accept = 1;
      end
    end
  end

  // Compare process: every register output, handshake and flags, mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 14; i++) chk($sformatf("reg%0d", i), dut_regs[i], m_regs[i]);
      chk("pending", {31'd0, pending}, {31'd0, (m_q_sel.size() != 0)});
      chk("selerr", {31'd0, sel_err}, {31'd0, m_sel_err});
      chk("ready", {31'd0, wr_ready},
          {31'd0, (!rst && ((m_q_sel.size() == 0) || !hold))});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] s, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_sel   = s;
    wr_data  = d;
  endtask

  initial begin
    tick();
    tick();
    check_en = 1'b1;
    rst = 1'b0;
    #1;
    chk("lit_ready_after_reset", {31'd0, wr_ready}, 32'd1);
    chk("lit_pc_reset", dut_regs[8], PC_RST);
    chk("lit_selerr_reset", {31'd0, sel_err}, 32'd0);

    // Back-to-back writes
    req(4'd10, 32'hDEAD_BEEF);
    tick();
    req(4'd5, 32'h1234_5678);
    #1;
    chk("lit_ready_b2b", {31'd0, wr_ready}, 32'd1);
    chk("lit_temp1_not_yet", dut_regs[10], 32'd0);
    tick();
    chk("lit_temp1", dut_regs[10], 32'hDEAD_BEEF);
    chk("lit_pending_b2b", {31'd0, pending}, 32'd1);
    wr_valid = 1'b0;
    tick();
    chk("lit_g5", dut_regs[5], 32'h1234_5678);
    chk("lit_pending_drained", {31'd0, pending}, 32'd0);

    // g0 write and invalid code
    req(4'd0, 32'hFFFF_FFFF);
    tick();
    req(4'd15, 32'hAAAA_5555);
    tick();
    chk("lit_g0_zero", dut_regs[0], 32'd0);
    chk("lit_selerr_before", {31'd0, sel_err}, 32'd0);
    wr_valid = 1'b0;
    tick();
    chk("lit_selerr_set", {31'd0, sel_err}, 32'd1);
    chk("lit_temp1_kept", dut_regs[10], 32'hDEAD_BEEF);
    tick();
    chk("lit_selerr_sticky", {31'd0, sel_err}, 32'd1);

    // Hold with two requests queued
    hold = 1'b1;
    req(4'd1, 32'h1111_1111);
    tick();
    req(4'd2, 32'h2222_2222);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lit_ready_hold", {31'd0, wr_ready}, 32'd0);
      tick();
      chk("lit_g1_frozen", dut_regs[1], 32'd0);
    end
    hold = 1'b0;
    tick();
    chk("lit_g1_after_hold", dut_regs[1], 32'h1111_1111);
    chk("lit_pending_second", {31'd0, pending}, 32'd1);
    wr_valid = 1'b0;
    tick();
    chk("lit_g2", dut_regs[2], 32'h2222_2222);

    // PC wrap, then commit beating increment
    req(4'd8, 32'hFFFF_FFFC);
    tick();
    wr_valid = 1'b0;
    tick();
    chk("lit_pc_loaded", dut_regs[8], 32'hFFFF_FFFC);
    pcinc = 1'b1;
    tick();
    pcinc = 1'b0;
    chk("lit_pc_wrap", dut_regs[8], 32'd0);
    req(4'd8, 32'h0000_0100);
    tick();
    wr_valid = 1'b0;
    pcinc = 1'b1;
    tick();
    pcinc = 1'b0;
    chk("lit_pc_commit_wins", dut_regs[8], 32'h0000_0100);

    // Reset on the commit edge loses the write
    req(4'd13, 32'h8000_0001);
    tick();
    wr_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("lit_ir_lost", dut_regs[13], 32'd0);
    chk("lit_pending_reset", {31'd0, pending}, 32'd0);
    chk("lit_pc_after_reset", dut_regs[8], PC_RST);
    rst = 1'b0;
    tick();
    chk("lit_ir_still_zero", dut_regs[13], 32'd0);

    // Randomized traffic, honouring the hold-until-accepted rule for requests
    for (int c = 0; c < 4000; c++) begin
      if (wr_valid && m_last_accept) wr_valid = 1'b0;
      if (!wr_valid && $urandom_range(9) < 7) begin
        wr_valid = 1'b1;
        wr_sel   = 4'($urandom_range(15));
        wr_data  = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : $urandom;
      end
      rst   = ($urandom_range(199) == 0);
      hold  = ($urandom_range(9) < 3);
      pcinc = ($urandom_range(9) < 4);
      tick();
    end
    wr_valid = 1'b0;
    rst = 1'b0;
    hold = 1'b0;
    pcinc = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
